// File: rtl/serial_pkg.sv
// Definitions shared by the serial transmit and receive blocks: FSM encoding
// and the default word width both ends are built for.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serial_state_e;

  localparam int SERIAL_WIDTH = 4;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word on a valid/ready load
// and streams it out one bit per cycle with frame_start/last_bit markers.
module piso_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = SERIAL_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             last_bit
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_state_e    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             dout_n;
  logic             load;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign out_valid   = (state == SHIFT);
  assign frame_start = out_valid && (cnt == '0);
  assign last_bit    = out_valid && (cnt == CNT_LAST);
  // Ready on the last bit lets a new word follow with no idle cycle.
  assign load_ready  = !rst && ((state == IDLE) || last_bit);
  assign load        = load_valid && load_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    dout_n  = 1'b0;
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sreg_n  = data_in;
      dout_n  = head_bit(data_in);
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n  = cnt + CNT_W'(1);
        sreg_n = advance(sreg);
        dout_n = head_bit(advance(sreg));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sreg     <= '0;
      data_out <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sreg     <= sreg_n;
      data_out <= dout_n;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances share stimulus;
// expected bit streams are queued on each accepted load and popped by a monitor.
module tb_piso_tx;

  localparam int W = 4;

  typedef struct {
    bit           b;
    bit           first;
    bit           last;
    int           pos;
    logic [W-1:0] word;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         ready_m, dout_m, ov_m, fs_m, lb_m;
  logic         ready_l, dout_l, ov_l, fs_l, lb_l;

  exp_t         qm[$];
  exp_t         ql[$];
  logic [W-1:0] rec_m, rec_l;
  int           total = 0;
  int           bad = 0;
  bit           started = 1'b0;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .data_out(dout_m), .out_valid(ov_m),
    .frame_start(fs_m), .last_bit(lb_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .data_out(dout_l), .out_valid(ov_l),
    .frame_start(fs_l), .last_bit(lb_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected serial stream for one word, both bit orders.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back('{b: w[W-1-i], first: (i == 0), last: (i == W-1), pos: W-1-i, word: w});
      ql.push_back('{b: w[i],     first: (i == 0), last: (i == W-1), pos: i,     word: w});
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a word until accepted; the model accepts when no bits are left
  // pending beyond the one currently on the line.
  task automatic send(input logic [W-1:0] w);
    bit done = 1'b0;
    data_in    = w;
    load_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(posedge clk);
      if (!rst && qm.size() == 0) begin
        push_word(w);
        done = 1'b1;
      end
      #1;
    end
    if (!done) chk("load_timeout", 32'd0, 32'd1);
    load_valid = 1'b0;
    data_in    = W'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      qm.delete();
      ql.delete();
      #1;
    end
    rst        = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic mon_one(input bit lsb, input logic ov, input logic dout,
                         input logic fs, input logic lb);
    exp_t e;
    int   qs;
    string tag;
    tag = lsb ? "lsb" : "msb";
    qs  = lsb ? ql.size() : qm.size();
    if (ov === 1'b1) begin
      if (qs == 0) begin
        chk({tag, "_unexpected_bit"}, 32'd1, 32'd0);
      end else begin
        e = lsb ? ql.pop_front() : qm.pop_front();
        chk({tag, "_data"},  32'(dout), 32'(e.b));
        chk({tag, "_frame"}, 32'(fs),   32'(e.first));
        chk({tag, "_last"},  32'(lb),   32'(e.last));
        if (lsb) rec_l[e.pos] = dout;
        else     rec_m[e.pos] = dout;
        if (e.last) chk({tag, "_loopback"}, 32'(lsb ? rec_l : rec_m), 32'(e.word));
      end
    end else begin
      chk({tag, "_valid"},      32'(ov),   32'd0);
      chk({tag, "_idle_data"},  32'(dout), 32'd0);
      chk({tag, "_idle_frame"}, 32'(fs),   32'd0);
      chk({tag, "_idle_last"},  32'(lb),   32'd0);
      chk({tag, "_missing"},    32'(qs),   32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("ready_msb", 32'(ready_m), 32'(!rst && qm.size() <= 1));
      chk("ready_lsb", 32'(ready_l), 32'(!rst && ql.size() <= 1));
      mon_one(1'b0, ov_m, dout_m, fs_m, lb_m);
      mon_one(1'b1, ov_l, dout_l, fs_l, lb_l);
    end
  end

  initial begin
    // Reset held with a word offered: nothing may be accepted.
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 4'hF;
    @(posedge clk);
    started = 1'b1;
    #1;
    do_reset(2);
    cyc(1);

    send(4'b1011);
    cyc(6);
    send(4'b1011);
    send(4'b0110);
    cyc(6);
    send(4'b1000);
    cyc(6);

    // Abort mid-word after two bits, then confirm a clean restart.
    send(4'b1111);
    cyc(1);
    do_reset(1);
    cyc(1);
    send(4'b0101);
    cyc(6);

    foreach (data_in[i]) begin end
    send(4'h0);
    send(4'hF);
    send(4'hA);
    send(4'h5);
    cyc(6);

    repeat (150) begin
      if ($urandom_range(0, 19) == 0) begin
        send(W'($urandom));
        cyc($urandom_range(0, 3));
        do_reset($urandom_range(1, 2));
      end else begin
        send(W'($urandom));
        if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 3));
      end
    end
    cyc(W + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1, SHALL select serial order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  SHALL carry the parallel word to be serialised.
REQ-006 load_valid  input  1  SHALL indicate that data_in holds a word to transmit.
REQ-007 load_ready  output  1  SHALL indicate that the block accepts a word this cycle.
REQ-008 data_out  output  1  SHALL carry the serial bit stream, registered.
REQ-009 out_valid  output  1  SHALL be high in every cycle that data_out carries a payload bit.
REQ-010 frame_start  output  1  SHALL be high only in the cycle that carries the first bit of a word.
REQ-011 last_bit  output  1  SHALL be high only in the cycle that carries the final bit of a word.

Function
REQ-012 States SHALL be IDLE and SHIFT only.
REQ-013 A load SHALL occur on a rising edge where load_valid and load_ready are both 1.
REQ-014 load_ready SHALL be 1 in IDLE, and in SHIFT only while last_bit is 1; otherwise it SHALL be 0.
REQ-015 On a load, the word SHALL be captured into an internal shift register.
REQ-016 On a load, the state SHALL become SHIFT and the bit counter SHALL clear to 0.
REQ-017 For a load at edge k, bit i of the serial order (i = 0..WIDTH-1) SHALL appear on data_out in the cycle after edge k+i.
REQ-018 out_valid SHALL be 1 in SHIFT and 0 in IDLE.
REQ-019 frame_start SHALL be 1 when the counter is 0 in SHIFT.
REQ-020 last_bit SHALL be 1 when the counter equals WIDTH-1 in SHIFT.
REQ-021 The counter SHALL be $clog2(WIDTH) bits wide and SHALL increment by 1 per SHIFT cycle.
REQ-022 When last_bit is 1 and no load occurs, the next state SHALL be IDLE.
REQ-023 When last_bit is 1 and a load occurs, the block SHALL stay in SHIFT with zero idle cycles.
REQ-024 In that back-to-back case, the new word's first bit SHALL follow the previous last bit immediately and frame_start SHALL reassert.
REQ-025 data_out SHALL be 0 whenever out_valid is 0.
REQ-026 data_in and load_valid SHALL be ignored while load_ready is 0; the word in flight SHALL NOT be altered.
REQ-027 Reset SHALL take priority over a simultaneous load; the word is dropped.

Reset
REQ-028 While rst is 1 at a clock edge: state IDLE, counter 0, shift register 0, data_out 0, out_valid 0, frame_start 0, last_bit 0.
REQ-029 While rst is 1, load_ready SHALL be 0; it SHALL be 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-word SHALL abort transmission; no remaining bits SHALL be emitted after reset.

Structure
REQ-031 The state encoding (IDLE=0, SHIFT=1) SHALL live in shared package serial_pkg, reused by the serial receive blocks.
REQ-032 serial_pkg SHALL also hold the default WIDTH constant, so transmitter and receiver agree.
REQ-033 The block SHALL be self-contained with no sub-module; shifter, counter and FSM are inline.

Verification
REQ-034 Reset: hold rst=1 for 2 cycles with load_valid=1 -> all outputs 0 and no word accepted.
REQ-035 Single word: WIDTH=4, MSB_FIRST=1, load 4'b1011 -> data_out 1,0,1,1 over 4 cycles.
REQ-036 Same single word -> frame_start on bit 1 only, last_bit on bit 4 only, then IDLE with out_valid=0.
REQ-037 Back-to-back: load 4'b1011, then 4'b0110 on its last_bit cycle -> 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no gap.
REQ-038 LSB-first: MSB_FIRST=0, load 4'b1000 -> data_out 0,0,0,1.
REQ-039 Mid-word reset: assert rst after 2 bits of 4'b1111 -> out_valid=0 next cycle; load 4'b0101 afterwards -> 0,1,0,1 correctly.
REQ-040 Loopback: drive data_out into the existing sipo (WIDTH=4) and sample its parallel output after last_bit -> it equals each loaded word, for words 0x0, 0xF, 0xA, 0x5.
